// File: rtl/ptp_arb_pkg.sv
// Shared types and constants for the PTP / TSN transmit arbiter.
package ptp_arb_pkg;
  localparam int DATA_W    = 134;
  localparam int PKT_CNT_W = 32;
  localparam int TO_CNT_W  = 16;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GNT_PTP,
    ST_GNT_DAT,
    ST_END
  } arb_state_t;
endpackage

// File: rtl/ptp_tx_arbiter_if.sv
// Packet bus bundle: PTP source, TSN data source and MAC TX side of the arbiter.
interface ptp_tx_arbiter_if;
  import ptp_arb_pkg::*;

  logic              ptp_req;
  logic              ptp_data_wr;
  logic [DATA_W-1:0] ptp_data;
  logic              ptp_valid_wr;
  logic              ptp_valid;
  logic              ptp_ready;

  logic              dat_req;
  logic              dat_data_wr;
  logic [DATA_W-1:0] dat_data;
  logic              dat_valid_wr;
  logic              dat_valid;
  logic              dat_ready;

  logic              out_data_wr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid_wr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output ptp_req, ptp_data_wr, ptp_data, ptp_valid_wr, ptp_valid,
    output dat_req, dat_data_wr, dat_data, dat_valid_wr, dat_valid,
    output out_ready,
    input  ptp_ready, dat_ready,
    input  out_data_wr, out_data, out_valid_wr, out_valid
  );

  modport slave (
    input  ptp_req, ptp_data_wr, ptp_data, ptp_valid_wr, ptp_valid,
    input  dat_req, dat_data_wr, dat_data, dat_valid_wr, dat_valid,
    input  out_ready,
    output ptp_ready, dat_ready,
    output out_data_wr, out_data, out_valid_wr, out_valid
  );
endinterface

// File: rtl/ptp_arb_out_reg.sv
// Registered MAC-side output stage; a descriptor arriving together with a data
// word is held one cycle so the word always reaches the MAC first.
module ptp_arb_out_reg
  import ptp_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              src_data_wr,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid_wr,
  input  logic              src_valid,
  output logic              mac_data_wr,
  output logic [DATA_W-1:0] mac_data,
  output logic              mac_valid_wr,
  output logic              mac_valid
);
  logic skid_vld_p1;
  logic skid_valid_p1;

  // stage p1: one-cycle output register plus descriptor skid
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_data_wr  <= 1'b0;
      mac_data     <= '0;
      mac_valid_wr <= 1'b0;
      mac_valid    <= 1'b0;
      skid_vld_p1  <= 1'b0;
    end else begin
      mac_data_wr <= src_data_wr;
      if (src_data_wr) mac_data <= src_data;
      if (skid_vld_p1) begin
        mac_valid_wr <= 1'b1;
        mac_valid    <= skid_valid_p1;
        skid_vld_p1  <= 1'b0;
      end else if (src_valid_wr && src_data_wr) begin
        mac_valid_wr <= 1'b0;
        skid_vld_p1  <= 1'b1;
      end else begin
        mac_valid_wr <= src_valid_wr;
        if (src_valid_wr) mac_valid <= src_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (src_valid_wr && src_data_wr) skid_valid_p1 <= src_valid;
  end
endmodule

// File: rtl/ptp_tx_arbiter.sv
// Strict-priority PTP / TSN packet arbiter in front of the MAC TX path.
// Optional starvation guard for the data source: PTP_ARB_STARVE_GUARD_EN.
module ptp_tx_arbiter
  import ptp_arb_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 256
`ifdef PTP_ARB_STARVE_GUARD_EN
  ,
  parameter int MAX_PTP_BURST = 4
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  ptp_tx_arbiter_if.slave      bus,
  output logic [PKT_CNT_W-1:0] ptp_pkt_cnt,
  output logic [PKT_CNT_W-1:0] dat_pkt_cnt,
  output logic [TO_CNT_W-1:0]  timeout_cnt,
  output logic                 busy
);
  localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);

  arb_state_t        state;
  logic [TMR_W-1:0]  tmr;
  logic              seen_wr;
  logic              sel_data_wr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid_wr;
  logic              sel_valid;
  logic              guard_hold;
  logic              pick_ptp;
  logic              pick_dat;
  logic              timeout_hit;

  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // only the granted source reaches the output stage
  always_comb begin
    sel_data_wr  = 1'b0;
    sel_data     = '0;
    sel_valid_wr = 1'b0;
    sel_valid    = 1'b0;
    if (state == ST_GNT_PTP) begin
      sel_data_wr  = bus.ptp_data_wr;
      sel_data     = bus.ptp_data;
      sel_valid_wr = bus.ptp_valid_wr;
      sel_valid    = bus.ptp_valid;
    end else if (state == ST_GNT_DAT) begin
      sel_data_wr  = bus.dat_data_wr;
      sel_data     = bus.dat_data;
      sel_valid_wr = bus.dat_valid_wr;
      sel_valid    = bus.dat_valid;
    end
  end

`ifdef PTP_ARB_STARVE_GUARD_EN
  localparam int BURST_W = $clog2(MAX_PTP_BURST + 1);
  logic [BURST_W-1:0] burst;

  assign guard_hold = bus.dat_req && (burst >= BURST_W'(MAX_PTP_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      burst <= '0;
    end else if (state == ST_IDLE && bus.out_ready) begin
      if (pick_dat) burst <= '0;
      else if (pick_ptp && bus.dat_req) burst <= burst + 1'b1;
    end
  end
`else
  assign guard_hold = 1'b0;
`endif

  assign pick_ptp    = bus.ptp_req && !guard_hold;
  assign pick_dat    = bus.dat_req && !pick_ptp;
  assign timeout_hit = !seen_wr && !sel_data_wr && !sel_valid_wr &&
                       (tmr == TMR_W'(GRANT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      seen_wr     <= 1'b0;
      ptp_pkt_cnt <= '0;
      dat_pkt_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmr     <= '0;
          seen_wr <= 1'b0;
          if (bus.out_ready && pick_ptp) state <= ST_GNT_PTP;
          else if (bus.out_ready && pick_dat) state <= ST_GNT_DAT;
        end
        ST_GNT_PTP, ST_GNT_DAT: begin
          if (sel_valid_wr) begin
            state <= ST_END;
            if (state == ST_GNT_PTP) ptp_pkt_cnt <= ptp_pkt_cnt + 1'b1;
            else dat_pkt_cnt <= dat_pkt_cnt + 1'b1;
          end else if (timeout_hit) begin
            state       <= ST_END;
            timeout_cnt <= sat_inc(timeout_cnt);
          end else if (sel_data_wr) begin
            seen_wr <= 1'b1;
          end else if (!seen_wr) begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // the descriptor strobe releases the grant in the same cycle
  assign bus.ptp_ready = (state == ST_GNT_PTP) && !bus.ptp_valid_wr;
  assign bus.dat_ready = (state == ST_GNT_DAT) && !bus.dat_valid_wr;
  assign busy          = (state != ST_IDLE);

  ptp_arb_out_reg u_out_reg (
    .clk          (clk),
    .rst          (reset),
    .src_data_wr  (sel_data_wr),
    .src_data     (sel_data),
    .src_valid_wr (sel_valid_wr),
    .src_valid    (sel_valid),
    .mac_data_wr  (bus.out_data_wr),
    .mac_data     (bus.out_data),
    .mac_valid_wr (bus.out_valid_wr),
    .mac_valid    (bus.out_valid)
  );
endmodule
